// File: rtl/led_ctrl_multi.sv
// led_ctrl_multi: debounced push button that steps a bank of LEDs through OFF/ON/BLINK/CHASE.
// Latency: 2-flop sync + DEBOUNCE_CYCLES to press_pulse, and one more edge to mode/led_on.
// Backpressure: none; the button is sampled every cycle, and presses closer than the debounce window are merged.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   push_button  raw active-high button, asynchronous to clk
//   led_on       registered LED drive, 1 = lit
//   mode         current mode: 0 OFF, 1 ON, 2 BLINK, 3 CHASE
//   press_pulse  one-cycle strobe per accepted press
//
// Optional feature: define LED_CTRL_LONGPRESS_EN to force OFF after LONG_CYCLES of continuous hold.

module led_ctrl_multi #(
  parameter int NUM_LEDS        = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 12500000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_button,
  output logic [NUM_LEDS-1:0] led_on,
  output logic [1:0]          mode,
  output logic                press_pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CHASE = 2'd3
  } mode_t;

  // Synchroniser and debounce state
  logic            sync_1;
  logic            btn_s;
  logic            btn_db;
  logic [DB_W-1:0] cnt;
  logic            db_hit;

  // Display state
  mode_t           state;
  mode_t           state_nxt;
  logic            mode_chg;
  logic [TK_W-1:0] tick_cnt;
  logic            tick;
  logic            phase;
  logic            phase_nxt;
  logic [NUM_LEDS-1:0] chase;
  logic [NUM_LEDS-1:0] chase_nxt;
  logic [NUM_LEDS-1:0] led_nxt;
  logic            long_hit;

  assign mode = state;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_1 <= push_button;
      btn_s  <= sync_1;
    end
  end

  // The level is accepted on the DEBOUNCE_CYCLES-th consecutive cycle that it differs.
  assign db_hit = (btn_s != btn_db) && (cnt == DB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      btn_db      <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= db_hit & btn_s;
      if (btn_s == btn_db) begin
        cnt <= '0;
      end else if (db_hit) begin
        btn_db <= btn_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

`ifdef LED_CTRL_LONGPRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold;

  // Saturating one past the fire value makes the override happen once per hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (!btn_db) begin
      hold <= '0;
    end else if (hold != HOLD_SAT) begin
      hold <= hold + HOLD_W'(1);
    end
  end

  assign long_hit = (hold == HOLD_FIRE);
`else
  // LONG_CYCLES only matters when the long-press feature is built in.
  localparam int long_cycles_unused = LONG_CYCLES;
  assign long_hit = 1'b0;
`endif

  assign tick = (tick_cnt == TK_LAST);

  // Next mode: a long press overrides, otherwise each press steps the mode once.
  always_comb begin
    state_nxt = state;
    mode_chg  = 1'b0;
    if (long_hit) begin
      state_nxt = MODE_OFF;
      mode_chg  = 1'b1;
    end else if (press_pulse) begin
      mode_chg = 1'b1;
      case (state)
        MODE_OFF:   state_nxt = MODE_ON;
        MODE_ON:    state_nxt = MODE_BLINK;
        MODE_BLINK: state_nxt = MODE_CHASE;
        default:    state_nxt = MODE_OFF;
      endcase
    end
  end

  // A mode change reloads the entry pattern and swallows a coincident tick.
  always_comb begin
    phase_nxt = phase;
    chase_nxt = chase;
    if (mode_chg) begin
      phase_nxt = 1'b1;
      chase_nxt = NUM_LEDS'(1);
    end else if (tick) begin
      phase_nxt = ~phase;
      chase_nxt = {chase[NUM_LEDS-2:0], chase[NUM_LEDS-1]};
    end
  end

  // LED drive is computed from the next state so it changes on the same edge as mode.
  always_comb begin
    led_nxt = '0;
    case (state_nxt)
      MODE_OFF:   led_nxt = '0;
      MODE_ON:    led_nxt = '1;
      MODE_BLINK: led_nxt = {NUM_LEDS{phase_nxt}};
      default:    led_nxt = chase_nxt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MODE_OFF;
      tick_cnt <= '0;
      phase    <= 1'b0;
      chase    <= '0;
      led_on   <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= (mode_chg || tick) ? '0 : tick_cnt + TK_W'(1);
      phase    <= phase_nxt;
      chase    <= chase_nxt;
      led_on   <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Bench for led_ctrl_multi: randomized button/reset stimulus against a window-based reference model.
// Expected outputs are queued each clock edge; a monitor pops and compares on the falling edge.
// Directed checks cover bounce rejection, press count, mode wrap and the long-press outcome.

module tb_led_ctrl_multi;

  localparam int N     = 4;
  localparam int DEB   = 4;
  localparam int TICK  = 8;
  localparam int LONG  = 32;
  localparam int HMAX  = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         push_button = 1'b0;
  logic [N-1:0] led_on;
  logic [1:0]   mode;
  logic         press_pulse;

  always #5 clk = ~clk;

  led_ctrl_multi #(
    .NUM_LEDS        (N),
    .DEBOUNCE_CYCLES (DEB),
    .TICK_CYCLES     (TICK),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_button (push_button),
    .led_on      (led_on),
    .mode        (mode),
    .press_pulse (press_pulse)
  );

  typedef struct packed {
    logic [N-1:0] led;
    logic [1:0]   mode;
    logic         pulse;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pulse_cnt = 0;

  // Reference model state: per-edge histories of synchronised and debounced level.
  bit bs_h [HMAX];
  bit db_h [HMAX];
  int n = 0;
  bit s1_m = 1'b0;
  int m_mode = 0;
  int m_entry = 0;
  bit m_pulse = 1'b0;

  always @(posedge clk) begin : model
    bit   flip;
    bit   old;
    bit   long_fire;
    int   k;
    exp_t e;
    n++;
    if (n >= HMAX) begin
      $display("FAIL model_history: cycle %0d exceeds history depth %0d", n, HMAX);
      $fatal(1);
    end
    if (rst) begin
      s1_m    = 1'b0;
      bs_h[n] = 1'b0;
      db_h[n] = 1'b0;
      m_mode  = 0;
      m_pulse = 1'b0;
      m_entry = n;
    end else begin
      bs_h[n] = s1_m;
      s1_m    = push_button;
      // Debounced level flips once the last DEB synchronised samples all disagree with it.
      old  = db_h[n-1];
      flip = (n - DEB >= 1);
      for (int i = 1; i <= DEB; i++)
        if (n - i >= 0 && bs_h[n-i] == old) flip = 1'b0;
      db_h[n] = flip ? ~old : old;
      long_fire = 1'b0;
`ifdef LED_CTRL_LONGPRESS_EN
      // Fires when the debounced level has been high for exactly LONG-1 prior edges.
      long_fire = (n - LONG - 1 >= 0);
      for (int j = n - LONG; j <= n - 2; j++)
        if (j < 0 || !db_h[j]) long_fire = 1'b0;
      if (long_fire && db_h[n-LONG-1]) long_fire = 1'b0;
`endif
      if (long_fire) begin
        m_mode  = 0;
        m_entry = n;
      end else if (m_pulse) begin
        m_mode  = (m_mode + 1) % 4;
        m_entry = n;
      end
      m_pulse = flip && db_h[n];
    end
    k = n - m_entry;
    e.mode  = 2'(m_mode);
    e.pulse = m_pulse;
    case (m_mode)
      0:       e.led = '0;
      1:       e.led = '1;
      2:       e.led = (((k / TICK) % 2) == 0) ? '1 : '0;
      default: e.led = N'(1) << ((k / TICK) % N);
    endcase
    sb.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (press_pulse === 1'b1) pulse_cnt++;
      if ({led_on, mode, press_pulse} !== e) begin
        errors++;
        $display("FAIL outputs @%0t: led_on=%b mode=%0d press_pulse=%b, required led_on=%b mode=%0d press_pulse=%b",
                 $time, led_on, mode, press_pulse, e.led, e.mode, e.pulse);
      end
    end
  end

  task automatic step(input logic b, input logic r);
    @(negedge clk);
    #2;
    push_button = b;
    rst = r;
  endtask

  task automatic hold_for(input logic b, input int cyc);
    for (int i = 0; i < cyc; i++) step(b, 1'b0);
  endtask

  task automatic chk(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  initial begin : stim
    int lvl;
    int dur;
    int drain;
    // Reset with the button held; button and reset released together.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    chk("reset_mode", mode, 0);
    chk("reset_led", led_on, 0);
    hold_for(1'b0, 8);
    chk("reset_no_press", pulse_cnt, 0);

    // Bounce shorter than the debounce window.
    hold_for(1'b1, 3);
    hold_for(1'b0, 2);
    hold_for(1'b1, 3);
    hold_for(1'b0, 12);
    chk("bounce_mode", mode, 0);
    chk("bounce_pulses", pulse_cnt, 0);

    // Clean press OFF -> ON.
    hold_for(1'b1, 10);
    hold_for(1'b0, 12);
    chk("press_mode_on", mode, 1);
    chk("press_led_on", led_on, 15);
    chk("press_pulses", pulse_cnt, 1);

    // ON -> BLINK, watch a few toggles; BLINK -> CHASE, watch a full rotation.
    hold_for(1'b1, 10);
    hold_for(1'b0, 30);
    chk("blink_mode", mode, 2);
    hold_for(1'b1, 10);
    hold_for(1'b0, 40);
    chk("chase_mode", mode, 3);

    // CHASE wraps to OFF.
    hold_for(1'b1, 10);
    hold_for(1'b0, 12);
    chk("wrap_mode", mode, 0);
    chk("wrap_led", led_on, 0);

    // To ON, then a 40-cycle hold from ON.
    hold_for(1'b1, 10);
    hold_for(1'b0, 12);
    chk("long_start_mode", mode, 1);
    hold_for(1'b1, 40);
    hold_for(1'b0, 15);
`ifdef LED_CTRL_LONGPRESS_EN
    chk("long_press_mode", mode, 0);
`else
    chk("long_press_mode", mode, 2);
`endif
    chk("total_pulses", pulse_cnt, 6);

    // Random button activity with occasional mid-pattern resets.
    for (int it = 0; it < 70; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
      end else begin
        lvl = $urandom_range(0, 1);
        dur = $urandom_range(1, 14);
        hold_for(lvl[0], dur);
      end
    end
    hold_for(1'b0, 20);

    drain = 0;
    while (sb.size() > 1 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    checks++;
    if (sb.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required at most 1", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
